// File: rtl/bspline_weighted_accumulator.sv
// Spline term accumulator: phi(x) = sum c_i*B_i(x), 3-stage pipe, result valid 3 cycles after the closing beat.
// Backpressure: basis_ready drops from closing beat until the result is taken; enable=0 freezes everything but coeff writes.
module bspline_weighted_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int DEGREE     = 3,
    parameter int NUM_COEFFS = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int ACC_GUARD  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  coeff_wr_en,
    input  logic [ADDR_WIDTH-1:0] coeff_wr_addr,
    input  logic [DATA_WIDTH-1:0] coeff_wr_data,
    input  logic                  basis_valid,
    output logic                  basis_ready,
    input  logic [DATA_WIDTH-1:0] basis_value,
    input  logic [ADDR_WIDTH-1:0] basis_index,
    input  logic                  basis_last,
    output logic                  spline_valid,
    input  logic                  spline_ready,
    output logic [DATA_WIDTH-1:0] spline_value,
    output logic                  spline_sat,
    output logic                  spline_err
);
    localparam int ACC_W  = DATA_WIDTH + ACC_GUARD;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int MEM_AW = $clog2(NUM_COEFFS);
    localparam int BC_W   = $clog2(DEGREE + 2);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [BC_W-1:0]       LAST_BEAT   = BC_W'(DEGREE);
    localparam logic [ADDR_WIDTH:0]   COEFF_LIMIT = (ADDR_WIDTH + 1)'(NUM_COEFFS);
    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(1) << (FRAC_BITS - 1);
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                   state;
    logic [BC_W-1:0]              beat_count;
    logic [DATA_WIDTH-1:0]        coeff_mem [NUM_COEFFS];

    logic                         s1_vld, s1_last;
    logic signed [DATA_WIDTH-1:0] s1_coeff, s1_basis;
    logic                         s2_vld, s2_last;
    logic signed [PROD_W-1:0]     s2_prod;
    logic signed [ACC_W-1:0]      acc;
    logic                         acc_done;
    logic                         err_acc;

    logic                         beat_fire, idx_oob, wr_oob, closing, beat_err, acc_fits;
    logic signed [ACC_W-1:0]      term;
    logic [ACC_W-DATA_WIDTH:0]    acc_hi;

    assign basis_ready = rst_n && enable && (state == ST_ACCUM);
    assign beat_fire   = basis_valid && basis_ready;
    assign idx_oob     = {1'b0, basis_index} >= COEFF_LIMIT;
    assign wr_oob      = {1'b0, coeff_wr_addr} >= COEFF_LIMIT;
    assign closing     = basis_last || (beat_count == LAST_BEAT);
    assign beat_err    = (basis_last && (beat_count != LAST_BEAT)) ||
                         (!basis_last && (beat_count == LAST_BEAT)) || idx_oob;

    // Round half-up, then keep the low accumulator bits; guard bits keep this exact for a full point.
    assign term     = ACC_W'((s2_prod + ROUND_HALF) >>> FRAC_BITS);
    assign acc_hi   = acc[ACC_W-1:DATA_WIDTH-1];
    assign acc_fits = (&acc_hi) || (~|acc_hi);

    // Coefficient file ignores enable; reads in the pipe see the pre-write value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COEFFS; i++) coeff_mem[i] <= '0;
        end else if (coeff_wr_en && !wr_oob) begin
            coeff_mem[coeff_wr_addr[MEM_AW-1:0]] <= coeff_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_ACCUM;
            beat_count   <= '0;
            s1_vld       <= 1'b0;
            s1_last      <= 1'b0;
            s1_coeff     <= '0;
            s1_basis     <= '0;
            s2_vld       <= 1'b0;
            s2_last      <= 1'b0;
            s2_prod      <= '0;
            acc          <= '0;
            acc_done     <= 1'b0;
            err_acc      <= 1'b0;
            spline_valid <= 1'b0;
            spline_value <= '0;
            spline_sat   <= 1'b0;
            spline_err   <= 1'b0;
        end else if (enable) begin
            s1_vld  <= beat_fire;
            s1_last <= beat_fire && closing;
            if (beat_fire) begin
                s1_basis <= basis_value;
                s1_coeff <= idx_oob ? '0 : coeff_mem[basis_index[MEM_AW-1:0]];
            end
            s2_vld  <= s1_vld;
            s2_last <= s1_vld && s1_last;
            if (s1_vld) s2_prod <= s1_coeff * s1_basis;
            if (s2_vld) acc <= acc + term;
            if (s2_vld && s2_last) acc_done <= 1'b1;

            case (state)
                ST_ACCUM: begin
                    if (beat_fire) begin
                        beat_count <= beat_count + 1'b1;
                        if (beat_err) err_acc <= 1'b1;
                        if (closing) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (acc_done) begin
                        spline_value <= acc_fits ? acc[DATA_WIDTH-1:0] :
                                        (acc[ACC_W-1] ? SAT_MIN : SAT_MAX);
                        spline_sat   <= !acc_fits;
                        spline_err   <= err_acc;
                        spline_valid <= 1'b1;
                        state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (spline_ready) begin
                        spline_valid <= 1'b0;
                        acc          <= '0;
                        acc_done     <= 1'b0;
                        beat_count   <= '0;
                        err_acc      <= 1'b0;
                        state        <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_bspline_weighted_accumulator.sv
// Directed bench for bspline_weighted_accumulator (NUM_COEFFS=32 build so index 0x3F is out of range).
module tb_bspline_weighted_accumulator;
    logic        clk = 1'b0;
    logic        rst_n, enable;
    logic        coeff_wr_en;
    logic [5:0]  coeff_wr_addr;
    logic [31:0] coeff_wr_data;
    logic        basis_valid, basis_ready, basis_last;
    logic [31:0] basis_value;
    logic [5:0]  basis_index;
    logic        spline_valid, spline_ready, spline_sat, spline_err;
    logic [31:0] spline_value;

    int compared   = 0;
    int mismatched = 0;

    logic [5:0]  idx_q [4];
    logic [31:0] val_q;

    always #5 clk = ~clk;

    bspline_weighted_accumulator #(
        .DATA_WIDTH(32), .FRAC_BITS(16), .DEGREE(3),
        .NUM_COEFFS(32), .ADDR_WIDTH(6), .ACC_GUARD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr), .coeff_wr_data(coeff_wr_data),
        .basis_valid(basis_valid), .basis_ready(basis_ready), .basis_value(basis_value),
        .basis_index(basis_index), .basis_last(basis_last),
        .spline_valid(spline_valid), .spline_ready(spline_ready), .spline_value(spline_value),
        .spline_sat(spline_sat), .spline_err(spline_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        coeff_wr_en = 1'b1; coeff_wr_addr = a; coeff_wr_data = d;
        step();
        coeff_wr_en = 1'b0;
    endtask

    task automatic set_pt(input logic [5:0] i0, input logic [5:0] i1, input logic [5:0] i2,
                          input logic [5:0] i3, input logic [31:0] v);
        idx_q[0] = i0; idx_q[1] = i1; idx_q[2] = i2; idx_q[3] = i3; val_q = v;
    endtask

    // Drives n beats; optionally a coefficient write lands in the same cycle as beat wr_at.
    task automatic beats(input int n, input bit use_last, input int wr_at,
                         input logic [5:0] wa, input logic [31:0] wd);
        for (int i = 0; i < n; i++) begin
            basis_valid = 1'b1;
            basis_index = idx_q[i];
            basis_value = val_q;
            basis_last  = use_last && (i == n - 1);
            if (i == wr_at) begin
                coeff_wr_en = 1'b1; coeff_wr_addr = wa; coeff_wr_data = wd;
            end
            chk1("beat_ready", basis_ready, 1'b1);
            step();
            coeff_wr_en = 1'b0;
        end
        basis_valid = 1'b0;
        basis_last  = 1'b0;
    endtask

    task automatic result(input string tag, input logic [31:0] ev, input logic es, input logic ee);
        step();
        chk1({tag, "_lat1"}, spline_valid, 1'b0);
        step();
        chk1({tag, "_lat2"}, spline_valid, 1'b0);
        step();
        chk1({tag, "_valid"}, spline_valid, 1'b1);
        chk({tag, "_value"}, spline_value, ev);
        chk1({tag, "_sat"}, spline_sat, es);
        chk1({tag, "_err"}, spline_err, ee);
    endtask

    task automatic handshake(input string tag);
        spline_ready = 1'b1;
        step();
        spline_ready = 1'b0;
        chk1({tag, "_drop"}, spline_valid, 1'b0);
        chk1({tag, "_rdy"}, basis_ready, 1'b1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; enable = 1'b1; coeff_wr_en = 1'b0; coeff_wr_addr = '0; coeff_wr_data = '0;
        basis_valid = 1'b0; basis_value = '0; basis_index = '0; basis_last = 1'b0;
        spline_ready = 1'b0;
        val_q = '0;
        for (int i = 0; i < 4; i++) idx_q[i] = '0;
        repeat (3) step();
        chk1("rst_valid", spline_valid, 1'b0);
        chk("rst_value", spline_value, 32'h0);
        chk1("rst_sat", spline_sat, 1'b0);
        chk1("rst_err", spline_err, 1'b0);
        chk1("rst_ready", basis_ready, 1'b0);
        rst_n = 1'b1;
        step();
        chk1("post_rst_ready", basis_ready, 1'b1);

        // Four terms of 0.25 against 1,2,3,4 -> 2.5
        wr(6'd4, 32'h0001_0000); wr(6'd5, 32'h0002_0000);
        wr(6'd6, 32'h0003_0000); wr(6'd7, 32'h0004_0000);
        set_pt(6'd4, 6'd5, 6'd6, 6'd7, 32'h0000_4000);
        beats(4, 1'b1, -1, '0, '0);
        result("basic", 32'h0002_8000, 1'b0, 1'b0);
        handshake("basic_hs");

        // Short frame: -1.5 * 0.5 -> -0.75, err
        wr(6'd0, 32'hFFFE_8000);
        set_pt(6'd0, 6'd0, 6'd0, 6'd0, 32'h0000_8000);
        beats(1, 1'b1, -1, '0, '0);
        result("short", 32'hFFFF_4000, 1'b0, 1'b1);
        handshake("short_hs");

        // Positive saturation
        for (int i = 0; i < 4; i++) wr(6'(i), 32'h7FFF_0000);
        set_pt(6'd0, 6'd1, 6'd2, 6'd3, 32'h0001_0000);
        beats(4, 1'b1, -1, '0, '0);
        result("satp", 32'h7FFF_FFFF, 1'b1, 1'b0);
        handshake("satp_hs");

        // Negative saturation, then hold the result against backpressure
        for (int i = 0; i < 4; i++) wr(6'(i), 32'h8001_0000);
        beats(4, 1'b1, -1, '0, '0);
        result("satn", 32'h8000_0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("hold_valid", spline_valid, 1'b1);
            chk("hold_value", spline_value, 32'h8000_0000);
            chk1("hold_sat", spline_sat, 1'b1);
            chk1("hold_ready", basis_ready, 1'b0);
        end
        handshake("satn_hs");

        // Same-cycle write to c[5] on the beat reading index 5: old value first, new value next point
        set_pt(6'd4, 6'd5, 6'd6, 6'd7, 32'h0000_4000);
        beats(4, 1'b1, 1, 6'd5, 32'h0003_0000);
        result("rbw_old", 32'h0002_8000, 1'b0, 1'b0);
        handshake("rbw_old_hs");
        beats(4, 1'b1, -1, '0, '0);
        result("rbw_new", 32'h0002_C000, 1'b0, 1'b0);
        handshake("rbw_new_hs");

        // Out-of-range index contributes zero and flags err
        set_pt(6'd4, 6'd5, 6'd6, 6'h3F, 32'h0000_4000);
        beats(4, 1'b1, -1, '0, '0);
        result("oob", 32'h0001_C000, 1'b0, 1'b1);
        handshake("oob_hs");

        // Four beats without basis_last still close the point, with err
        set_pt(6'd4, 6'd5, 6'd6, 6'd7, 32'h0000_4000);
        beats(4, 1'b0, -1, '0, '0);
        result("nolast", 32'h0002_C000, 1'b0, 1'b1);
        handshake("nolast_hs");

        // enable low for 3 cycles after the closing beat stretches latency by 3
        beats(4, 1'b1, -1, '0, '0);
        enable = 1'b0;
        repeat (3) step();
        chk1("en_frozen_valid", spline_valid, 1'b0);
        chk1("en_frozen_ready", basis_ready, 1'b0);
        enable = 1'b1;
        k = 0;
        while (!spline_valid && k < 20) begin
            step();
            k++;
        end
        chk1("en_wait", spline_valid, 1'b1);
        chk("en_latency", 32'(k), 32'd3);
        chk("en_value", spline_value, 32'h0002_C000);
        handshake("en_hs");

        // Reset mid-point discards the partial sum and clears coefficients
        beats(2, 1'b0, -1, '0, '0);
        rst_n = 1'b0;
        step();
        step();
        chk1("mrst_valid", spline_valid, 1'b0);
        chk("mrst_value", spline_value, 32'h0);
        chk1("mrst_sat", spline_sat, 1'b0);
        chk1("mrst_err", spline_err, 1'b0);
        chk1("mrst_ready", basis_ready, 1'b0);
        rst_n = 1'b1;
        wr(6'd8, 32'h0001_0000); wr(6'd9, 32'h0002_0000); wr(6'd10, 32'h0003_0000);
        set_pt(6'd8, 6'd9, 6'd10, 6'd4, 32'h0000_8000);
        beats(4, 1'b1, -1, '0, '0);
        result("after_rst", 32'h0003_0000, 1'b0, 1'b0);
        handshake("after_rst_hs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
